// File: rtl/mips_mem_pkg.sv
// Shared memory-path constants and types for the MIPS core: used by the RAM,
// instruction fetch and load/store units.
package mips_mem_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] waddr_t;

endpackage

// File: rtl/mips_ram_array.sv
// Plain single-port storage array with a write enable and a registered read.
// It is kept free of resets so that it maps onto block RAM.
module mips_ram_array #(
  parameter int ADDR_W = mips_mem_pkg::ADDR_W,
  parameter int DATA_W = mips_mem_pkg::DATA_W,
  parameter int DEPTH  = mips_mem_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the storage array and its read register have no reset. A reset
  // would stop the array mapping to block RAM. The top level masks the
  // output until the first read after reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep the read-before-write ordering the
    // same in simulation and in the synthesised netlist.
    if (we) mem[addr] <= wdata;
    if (re) rdata     <= mem[addr];
  end

endmodule

// File: rtl/mips_ram.sv
// 1024 x 32 single-port synchronous RAM. It decodes cs/rd into read and write
// strobes, holds the read result until the next read, and gates the output with oe.
module mips_ram #(
  parameter int ADDR_W = mips_mem_pkg::ADDR_W,
  parameter int DATA_W = mips_mem_pkg::DATA_W,
  parameter int DEPTH  = mips_mem_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              cs,
  input  logic              rd,
  input  logic              oe,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data
);

  logic              rd_en;
  logic              wr_en;
  logic              rdata_vld;
  logic [DATA_W-1:0] rdata_q;

  assign rd_en = cs & rd;
  assign wr_en = cs & ~rd;

  mips_ram_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (wr_en),
    .re    (rd_en),
    .addr  (addr),
    .wdata (write_data),
    .rdata (rdata_q)
  );

  // This flag acts as the async clear of the read register. It keeps the
  // output at zero from reset until the next read edge. The data register
  // itself can then stay inside the block RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rdata_vld <= 1'b0;
    else if (rd_en) rdata_vld <= 1'b1;
  end

  assign read_data = (rd_en && oe && rdata_vld) ? rdata_q : '0;

endmodule

// File: tb/tb_mips_ram.sv
// Scoreboard bench for mips_ram. Stimulus queues the expected read_data and
// signals a sample point. The monitor pops each entry and compares it.
module tb_mips_ram;
  import mips_mem_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  waddr_t addr;
  logic   cs, rd, oe;
  word_t  write_data;
  word_t  read_data;

  typedef struct {
    string name;
    word_t exp;
  } exp_t;

  exp_t exp_q[$];
  event sample_ev;
  int   checks = 0;
  int   errors = 0;

  mips_ram dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .cs         (cs),
    .rd         (rd),
    .oe         (oe),
    .write_data (write_data),
    .read_data  (read_data)
  );

  always #5 clk = ~clk;

  // Monitor: compares the output whenever the stimulus marks a sample point.
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sample_without_expectation: read_data=%h", read_data);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (read_data !== e.exp) begin
          errors++;
          $display("FAIL %s: read_data=%h expected=%h", e.name, read_data, e.exp);
        end
      end
    end
  end

  // Queue an expectation for the current time and let the monitor take it.
  task automatic expect_now(input string name, input word_t exp);
    exp_q.push_back('{name: name, exp: exp});
    -> sample_ev;
    #1;
  endtask

  // Apply controls after a falling edge, then sample 1 ns after the rising edge.
  task automatic cycle(input logic c, input logic r, input logic o,
                       input waddr_t a, input word_t wd,
                       input bit chk, input string name, input word_t exp);
    @(negedge clk);
    cs = c; rd = r; oe = o; addr = a; write_data = wd;
    @(posedge clk);
    #1;
    if (chk) expect_now(name, exp);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cs = 1'b1; rd = 1'b1; oe = 1'b1; addr = '0; write_data = '0;
    #2;
    expect_now("reset_asserted", 32'h0);

    // Release reset with the RAM deselected. Then enable without an edge.
    @(negedge clk);
    rst = 1'b0; cs = 1'b0;
    @(posedge clk);
    #1;
    cs = 1'b1; rd = 1'b1; oe = 1'b1;
    #1;
    expect_now("post_reset_no_read", 32'h0);

    cycle(1, 0, 0, 10'd5, 32'hDEAD_BEEF, 1, "write_addr5", 32'h0);
    cycle(1, 1, 1, 10'd5, 32'h0,         1, "read_addr5",  32'hDEAD_BEEF);
    oe = 1'b0; #1;
    expect_now("oe_drop_comb", 32'h0);
    oe = 1'b1; #1;
    expect_now("oe_raise_comb", 32'hDEAD_BEEF);
    cycle(1, 1, 0, 10'd5, 32'h0, 1, "read_oe0",    32'h0);
    cycle(0, 1, 1, 10'd5, 32'h0, 1, "read_cs0",    32'h0);
    cycle(1, 1, 1, 10'd5, 32'h0, 1, "reread_addr5", 32'hDEAD_BEEF);

    // Address extremes. A write must leave the previous read result in place.
    cycle(1, 0, 1, 10'd0,    32'h0000_0001, 1, "write_addr0",    32'h0);
    cycle(1, 1, 1, 10'd0,    32'h0,         1, "read_addr0",     32'h0000_0001);
    cycle(1, 0, 1, 10'd1023, 32'h8000_0000, 1, "write_addr1023", 32'h0);
    rd = 1'b1; #1;
    expect_now("write_holds_rdata", 32'h0000_0001);
    cycle(1, 1, 1, 10'd1023, 32'h0, 1, "read_addr1023", 32'h8000_0000);
    cycle(1, 1, 1, 10'd0,    32'h0, 1, "reread_addr0",  32'h0000_0001);

    // Overwrite on back-to-back edges, then a deselected write.
    cycle(1, 0, 1, 10'd100, 32'h1234_5678, 0, "", 32'h0);
    cycle(1, 0, 1, 10'd100, 32'hCAFE_F00D, 0, "", 32'h0);
    cycle(1, 1, 1, 10'd100, 32'h0,         1, "read_overwrite", 32'hCAFE_F00D);
    cycle(0, 0, 1, 10'd100, 32'h0,         1, "deselected_write", 32'h0);
    cycle(1, 1, 1, 10'd100, 32'h0,         1, "read_after_desel", 32'hCAFE_F00D);

    // Reset pulse between edges while a read is being presented.
    #1;
    rst = 1'b1; #1;
    expect_now("mid_reset_async", 32'h0);
    @(negedge clk);
    rst = 1'b0; #1;
    expect_now("after_release_pre_edge", 32'h0);
    @(posedge clk);
    #1;
    expect_now("read_after_reset", 32'hCAFE_F00D);

    #2;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: pending=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
